// File: rtl/debounce_ev_pkg.sv
// Shared types and width helpers for the debounce/event conditioner.
// Phase encoding of the hold (long-press / auto-repeat) tracker.
package debounce_ev_pkg;

  typedef enum logic {
    DB_PH_IDLE   = 1'b0,
    DB_PH_REPEAT = 1'b1
  } db_phase_e;

  function automatic int db_cnt_w(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

  function automatic int db_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_ev_ch.sv
// One switch channel: 2-FF sync, debounce, edge strobes,
// long-press and auto-repeat strobes.
module debounce_ev_ch
  import debounce_ev_pkg::*;
#(
  parameter int DEBOUNCE_TIME = 5000,
  parameter int LONG_TIME     = 0,
  parameter int REPEAT_TIME   = 0,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o,
  output logic repeat_o,
  output logic ev_o
);

  localparam int DW = db_cnt_w(DEBOUNCE_TIME);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_TIME - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic          sync1_q, sync2_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dcnt_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sw_i ^ INV;
      sync2_q <= sync1_q;
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Any agreeing cycle restarts the disagreement count.
  always_comb begin
    dcnt_d  = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (dcnt_q == DLAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign ev_o    = rise_d | fall_d;

  if (LONG_TIME > 0) begin : g_hold
    localparam int HW = db_cnt_w(db_max(LONG_TIME, REPEAT_TIME));
    localparam logic [HW-1:0] LLAST = HW'(LONG_TIME - 1);
    localparam logic [HW-1:0] RLAST =
      HW'(db_max(REPEAT_TIME, 1) - 1);
    localparam logic RPT_EN = (REPEAT_TIME > 0);

    db_phase_e     ph_q, ph_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_q, long_d;
    logic          rpt_q, rpt_d;
    logic          held;

    // Excludes the rise edge and the release edge.
    assign held = level_q & level_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        ph_q   <= DB_PH_IDLE;
        hcnt_q <= '0;
        long_q <= 1'b0;
        rpt_q  <= 1'b0;
      end else begin
        ph_q   <= ph_d;
        hcnt_q <= hcnt_d;
        long_q <= long_d;
        rpt_q  <= rpt_d;
      end
    end

    always_comb begin
      ph_d   = ph_q;
      hcnt_d = hcnt_q;
      if (!held) begin
        ph_d   = DB_PH_IDLE;
        hcnt_d = '0;
      end else begin
        unique case (ph_q)
          DB_PH_IDLE: begin
            if (hcnt_q == LLAST) begin
              hcnt_d = '0;
              ph_d   = DB_PH_REPEAT;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
          DB_PH_REPEAT: begin
            if (!RPT_EN || hcnt_q == RLAST) begin
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
          default: begin
            ph_d   = DB_PH_IDLE;
            hcnt_d = '0;
          end
        endcase
      end
    end

    always_comb begin
      long_d = held && (ph_q == DB_PH_IDLE)
               && (hcnt_q == LLAST);
      rpt_d  = held && RPT_EN && (ph_q == DB_PH_REPEAT)
               && (hcnt_q == RLAST);
    end

    assign long_o   = long_q;
    assign repeat_o = rpt_q;
  end else begin : g_nohold
    assign long_o   = 1'b0;
    assign repeat_o = 1'b0;
  end

endmodule

// File: rtl/debounce_ev.sv
// N-channel switch conditioner: per-channel debounce and
// event strobes plus a registered any-edge flag.
module debounce_ev
  import debounce_ev_pkg::*;
#(
  parameter int N             = 1,
  parameter int DEBOUNCE_TIME = 5000,
  parameter int LONG_TIME     = 0,
  parameter int REPEAT_TIME   = 0,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_switch,
  output logic [N-1:0] o_level,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_fall,
  output logic [N-1:0] o_long,
  output logic [N-1:0] o_repeat,
  output logic         o_any
);

  logic [N-1:0] ev;
  logic         any_q;

  for (genvar g = 0; g < N; g++) begin : g_ch
    debounce_ev_ch #(
      .DEBOUNCE_TIME (DEBOUNCE_TIME),
      .LONG_TIME     (LONG_TIME),
      .REPEAT_TIME   (REPEAT_TIME),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .sw_i     (i_switch[g]),
      .level_o  (o_level[g]),
      .rise_o   (o_rise[g]),
      .fall_o   (o_fall[g]),
      .long_o   (o_long[g]),
      .repeat_o (o_repeat[g]),
      .ev_o     (ev[g])
    );
  end

  // Built from next-state strobes so it lines up with them.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |ev;
    end
  end

  assign o_any = any_q;

endmodule

// File: tb/tb_debounce_ev.sv
// Scoreboard bench for debounce_ev: stimulus queues expected
// events, negedge monitors pop and compare on any strobe.
module tb_debounce_ev;

  typedef struct packed {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] lng;
    logic [1:0] rpt;
    logic [1:0] lvl;
    logic       any;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sw = 2'b00;
  logic [0:0] pin_a = 1'b1;

  logic [1:0] m_lvl, m_rise, m_fall, m_long, m_rpt;
  logic       m_any;
  logic [0:0] a_lvl, a_rise, a_fall, a_long, a_rpt;
  logic       a_any;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  ev_t q_m[$];
  ev_t q_a[$];
  ev_t am, em, aa, ea;

  debounce_ev #(
    .N(2), .DEBOUNCE_TIME(4), .LONG_TIME(10),
    .REPEAT_TIME(3), .ACTIVE_LOW(0)
  ) u_main (
    .i_clk(clk), .i_reset(rst_n), .i_switch(sw),
    .o_level(m_lvl), .o_rise(m_rise), .o_fall(m_fall),
    .o_long(m_long), .o_repeat(m_rpt), .o_any(m_any)
  );

  debounce_ev #(
    .N(1), .DEBOUNCE_TIME(4), .LONG_TIME(0),
    .REPEAT_TIME(3), .ACTIVE_LOW(1)
  ) u_alt (
    .i_clk(clk), .i_reset(rst_n), .i_switch(pin_a),
    .o_level(a_lvl), .o_rise(a_rise), .o_fall(a_fall),
    .o_long(a_long), .o_repeat(a_rpt), .o_any(a_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_ev(string nm, ev_t act, ev_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cyc=%0d r=%b f=%b l=%b p=%b v=%b a=%b, want cyc=%0d r=%b f=%b l=%b p=%b v=%b a=%b",
        nm, act.cyc, act.rise, act.fall, act.lng, act.rpt,
        act.lvl, act.any, exp.cyc, exp.rise, exp.fall,
        exp.lng, exp.rpt, exp.lvl, exp.any);
    end
  endtask

  task automatic chk_v(string nm, logic [15:0] act,
                       logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_m(int c, logic [1:0] r, logic [1:0] f,
                        logic [1:0] l, logic [1:0] p,
                        logic [1:0] v, logic a);
    ev_t e;
    e = '{cyc: c, rise: r, fall: f, lng: l, rpt: p,
          lvl: v, any: a};
    q_m.push_back(e);
  endtask

  task automatic push_a(int c, logic r, logic f, logic v);
    ev_t e;
    e = '{cyc: c, rise: {1'b0, r}, fall: {1'b0, f},
          lng: 2'b00, rpt: 2'b00, lvl: {1'b0, v},
          any: r | f};
    q_a.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (|{m_rise, m_fall, m_long, m_rpt, m_any}) begin
      am = '{cyc: cyc, rise: m_rise, fall: m_fall,
             lng: m_long, rpt: m_rpt, lvl: m_lvl, any: m_any};
      if (q_m.size() == 0) begin
        em = '0;
        chk_ev("main_unexpected", am, em);
      end else begin
        em = q_m.pop_front();
        chk_ev("main_ev", am, em);
      end
    end
  end

  always @(negedge clk) begin
    if (|{a_rise, a_fall, a_long, a_rpt, a_any}) begin
      aa = '{cyc: cyc, rise: {1'b0, a_rise},
             fall: {1'b0, a_fall}, lng: {1'b0, a_long},
             rpt: {1'b0, a_rpt}, lvl: {1'b0, a_lvl},
             any: a_any};
      if (q_a.size() == 0) begin
        ea = '0;
        chk_ev("alt_unexpected", aa, ea);
      end else begin
        ea = q_a.pop_front();
        chk_ev("alt_ev", aa, ea);
      end
    end
  end

  initial begin
    int b;
    int r;
    step(3);
    chk_v("rst_main",
      16'({m_lvl, m_rise, m_fall, m_long, m_rpt, m_any}), 16'h0);
    chk_v("rst_alt",
      16'({a_lvl, a_rise, a_fall, a_long, a_rpt, a_any}), 16'h0);
    rst_n = 1'b1;
    step(10);
    chk_v("idle_lvl_main", 16'(m_lvl), 16'h0);
    chk_v("idle_lvl_alt", 16'(a_lvl), 16'h0);

    // single rise, release just before long-press
    b = cyc;
    sw = 2'b01;
    push_m(b + 6, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1);
    step(10);
    sw = 2'b00;
    push_m(b + 16, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    step(15);

    // 3-cycle glitch rejected, 4-cycle pulse accepted
    sw = 2'b01;
    step(3);
    sw = 2'b00;
    step(12);
    chk_v("glitch_lvl", 16'(m_lvl), 16'h0);
    b = cyc;
    sw = 2'b01;
    push_m(b + 6, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1);
    step(4);
    sw = 2'b00;
    push_m(b + 10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    step(15);

    // long press and repeats on ch1
    b = cyc;
    sw = 2'b10;
    push_m(b + 6, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1);
    push_m(b + 16, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0);
    for (int i = 0; i < 8; i++)
      push_m(b + 19 + 3 * i, 2'b00, 2'b00, 2'b00, 2'b10,
             2'b10, 1'b0);
    step(36);
    chk_v("held_lvl", 16'(m_lvl), 16'h2);
    sw = 2'b00;
    push_m(b + 42, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
    step(15);

    // both channels together
    b = cyc;
    sw = 2'b11;
    push_m(b + 6, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1);
    step(8);
    sw = 2'b00;
    push_m(b + 14, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
    step(15);

    // active-low pin, no hold logic built
    b = cyc;
    pin_a = 1'b0;
    push_a(b + 6, 1'b1, 1'b0, 1'b1);
    step(40);
    chk_v("alt_held_lvl", 16'(a_lvl), 16'h1);
    pin_a = 1'b1;
    push_a(b + 46, 1'b0, 1'b1, 1'b0);
    step(15);

    // reset mid-count with ch1 already high
    b = cyc;
    sw = 2'b10;
    push_m(b + 6, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1);
    step(6);
    sw = 2'b11;
    step(4);
    chk_v("pre_rst_lvl", 16'(m_lvl), 16'h2);
    rst_n = 1'b0;
    #1;
    chk_v("mid_rst_main",
      16'({m_lvl, m_rise, m_fall, m_long, m_rpt, m_any}), 16'h0);
    step(2);
    rst_n = 1'b1;
    r = cyc;
    push_m(r + 6, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1);
    step(8);
    sw = 2'b00;
    push_m(r + 14, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
    step(15);

    chk_v("main_q_empty", 16'(q_m.size()), 16'h0);
    chk_v("alt_q_empty", 16'(q_a.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
